// File: rtl/fetch_sequencer_pkg.sv
// Shared constants for the fetch sequencer: opcodes, FSM encoding, PC width.
// Optional branch support is selected with the FETCH_BRANCH_EN macro.
package fetch_sequencer_pkg;

    localparam int PC_W = 2;

    localparam logic [1:0] OP_INC = 2'b00;
    localparam logic [1:0] OP_NOP = 2'b01;
    localparam logic [1:0] OP_BRZ = 2'b10;
    localparam logic [1:0] OP_HLT = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    localparam logic [7:0] RETIRED_MAX = 8'hFF;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == RETIRED_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/fetch_sequencer_pc_counter.sv
// Two-bit wrapping program counter with load and increment controls.
// Load takes priority over increment.
module pc_counter
    import fetch_sequencer_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            load,
    input  logic            inc,
    input  logic [PC_W-1:0] target,
    output logic [PC_W-1:0] count
);

    logic [PC_W-1:0] count_q;
    logic [PC_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = target;
        end else if (inc) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Non-overlapped FETCH/DECODE/EXECUTE sequencer for a 4-word, 2-bit RAM.
// Define FETCH_BRANCH_EN to make opcode 10 branch to 0 when status_in is low.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            run,
    input  logic            halt_req,
    input  logic [1:0]      ram_instr,
    input  logic            status_in,
    output logic [PC_W-1:0] pc,
    output logic [1:0]      ir,
    output logic            exec_inc,
    output logic            busy,
    output logic            halted,
    output logic [7:0]      retired
);

    state_t     state_q, state_d;
    logic [1:0] ir_q, ir_d;
    logic [7:0] retired_q, retired_d;
    logic       exec_inc_q, exec_inc_d;
    logic       busy_q, busy_d;
    logic       halted_q, halted_d;
    logic       pc_load;
    logic       pc_inc;
    logic       br_taken;

`ifdef FETCH_BRANCH_EN
    assign br_taken = (ir_q == OP_BRZ) && !status_in;
`else
    logic unused_status;
    assign unused_status = status_in;
    assign br_taken      = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        retired_d = retired_q;
        pc_load   = 1'b0;
        pc_inc    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (run && !halt_req) state_d = S_FETCH;
            end
            S_FETCH: begin
                ir_d    = ram_instr;
                state_d = S_DECODE;
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                retired_d = sat_inc(retired_q);
                if (ir_q == OP_HLT) begin
                    state_d = S_HALT;
                end else begin
                    pc_load = br_taken;
                    pc_inc  = !br_taken;
                    state_d = halt_req ? S_IDLE : S_FETCH;
                end
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
        // Outputs are registered, so derive them from the next state.
        exec_inc_d = (state_q == S_DECODE) && (ir_q == OP_INC);
        busy_d     = (state_d == S_FETCH) || (state_d == S_DECODE)
                  || (state_d == S_EXEC);
        halted_d   = (state_d == S_HALT);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            ir_q       <= OP_INC;
            retired_q  <= '0;
            exec_inc_q <= 1'b0;
            busy_q     <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            retired_q  <= retired_d;
            exec_inc_q <= exec_inc_d;
            busy_q     <= busy_d;
            halted_q   <= halted_d;
        end
    end

    pc_counter u_pc (
        .clock  (clock),
        .reset  (reset),
        .load   (pc_load),
        .inc    (pc_inc),
        .target ('0),
        .count  (pc)
    );

    assign ir       = ir_q;
    assign exec_inc = exec_inc_q;
    assign busy     = busy_q;
    assign halted   = halted_q;
    assign retired  = retired_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a cycle model queues expected outputs.
// Honours FETCH_BRANCH_EN the same way as the design.
module tb_fetch_sequencer;

    logic       clock = 1'b0;
    logic       reset, run, halt_req, status_in;
    logic [1:0] ram_instr, pc, ir;
    logic       exec_inc, busy, halted;
    logic [7:0] retired;
    logic [1:0] mem [4];

    int          n_vec  = 0;
    int          n_miss = 0;
    int          m_state;
    logic [1:0]  m_pc, m_ir;
    logic [7:0]  m_ret;
    logic [14:0] exp_q [$];
    string       scen;
    int          pulses;

    always #5 clock = ~clock;

    assign ram_instr = mem[pc];

    fetch_sequencer dut (
        .clock     (clock),
        .reset     (reset),
        .run       (run),
        .halt_req  (halt_req),
        .ram_instr (ram_instr),
        .status_in (status_in),
        .pc        (pc),
        .ir        (ir),
        .exec_inc  (exec_inc),
        .busy      (busy),
        .halted    (halted),
        .retired   (retired)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s got %h want %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [14:0] m_out();
        logic e, b, h;
        e = (m_state == 3) && (m_ir == 2'b00);
        b = (m_state >= 1) && (m_state <= 3);
        h = (m_state == 4);
        return {m_pc, m_ir, e, b, h, m_ret};
    endfunction

    task automatic step_model();
        logic taken;
`ifdef FETCH_BRANCH_EN
        taken = (m_ir == 2'b10) && !status_in;
`else
        taken = 1'b0;
`endif
        if (reset) begin
            m_state = 0; m_pc = 0; m_ir = 0; m_ret = 0;
        end else begin
            case (m_state)
                0: if (run && !halt_req) m_state = 1;
                1: begin m_ir = mem[m_pc]; m_state = 2; end
                2: m_state = 3;
                3: begin
                    if (m_ret != 8'hFF) m_ret = m_ret + 8'd1;
                    if (m_ir == 2'b11) begin
                        m_state = 4;
                    end else begin
                        m_pc    = taken ? 2'b00 : m_pc + 2'b01;
                        m_state = halt_req ? 0 : 1;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic tick();
        logic [14:0] got;
        step_model();
        exp_q.push_back(m_out());
        @(posedge clock);
        #1;
        got = {pc, ir, exec_inc, busy, halted, retired};
        if (exec_inc) pulses++;
        check(scen, {17'd0, got}, {17'd0, exp_q.pop_front()});
    endtask

    task automatic do_reset();
        reset = 1; run = 0; halt_req = 0;
        tick(); tick();
        reset = 0;
    endtask

    task automatic start();
        run = 1; tick(); run = 0;
    endtask

    task automatic wait_for(input int st, input int pcv, input int budget);
        int found = 0;
        for (int i = 0; i < budget; i++) begin
            if (m_state == st && m_pc == pcv[1:0]) begin
                found = 1;
                break;
            end
            tick();
        end
        check({scen, "_wait"}, found, 1);
    endtask

    initial begin
        reset = 1; run = 0; halt_req = 0; status_in = 0;
        mem[0] = 0; mem[1] = 0; mem[2] = 0; mem[3] = 0;

        scen = "reset";
        do_reset();
        check("reset_out", {17'd0, pc, ir, exec_inc, busy, halted, retired}, 0);

        scen = "all_inc";
        pulses = 0;
        start();
        for (int i = 0; i < 12; i++) tick();
        check("inc_pulses", pulses, 4);
        check("inc_retired", retired, 4);
        check("inc_pc_wrap", pc, 0);
        run = 1;
        for (int i = 0; i < 6; i++) tick();
        run = 0;

        scen = "halt_prog";
        do_reset();
        mem[0] = 0; mem[1] = 1; mem[2] = 3; mem[3] = 0;
        pulses = 0;
        start();
        for (int i = 0; i < 9; i++) tick();
        check("hlt_halted", halted, 1);
        check("hlt_pc", pc, 2);
        check("hlt_retired", retired, 3);
        check("hlt_pulses", pulses, 1);
        run = 1;
        for (int i = 0; i < 5; i++) tick();
        run = 0;
        check("hlt_sticky", {halted, busy}, 2'b10);

        scen = "halt_req";
        do_reset();
        mem[0] = 0; mem[1] = 1; mem[2] = 1; mem[3] = 1;
        start();
        wait_for(2, 1, 20);
        halt_req = 1; tick(); halt_req = 0;
        check("hreq_decode_busy", busy, 1);
        halt_req = 1; tick(); halt_req = 0;
        check("hreq_exec_idle", {busy, pc}, 3'b010);
        tick(); tick();
        check("hreq_stays_idle", busy, 0);

        scen = "reset_mid";
        do_reset();
        mem[0] = 0; mem[1] = 0; mem[2] = 0; mem[3] = 0;
        start();
        wait_for(3, 0, 10);
        reset = 1; tick(); reset = 0;
        check("rst_mid_out", {17'd0, pc, ir, exec_inc, busy, halted, retired}, 0);
        pulses = 0;
        for (int i = 0; i < 4; i++) tick();
        check("rst_no_inc", pulses, 0);
        start();
        tick(); tick();
        check("restart_inc", {exec_inc, pc}, 3'b100);
        for (int i = 0; i < 4; i++) tick();

        scen = "brz";
        do_reset();
        mem[0] = 0; mem[1] = 2; mem[2] = 1; mem[3] = 1;
        status_in = 0;
        start();
        for (int i = 0; i < 6; i++) tick();
`ifdef FETCH_BRANCH_EN
        check("brz_taken_pc", pc, 0);
`else
        check("brz_nop_pc", pc, 2);
`endif
        for (int i = 0; i < 6; i++) tick();
        status_in = 1;
        for (int i = 0; i < 15; i++) tick();
        status_in = 0;

        scen = "saturate";
        do_reset();
        mem[0] = 1; mem[1] = 1; mem[2] = 1; mem[3] = 1;
        start();
        for (int i = 0; i < 900; i++) tick();
        check("sat_retired", retired, 255);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have port clock  input  1  single rising-edge clock for all state.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset, sampled on rising clock.
REQ-003 SHALL have port run  input  1  start request, sampled in IDLE only.
REQ-004 SHALL have port halt_req  input  1  stop request, honoured at instruction boundary.
REQ-005 SHALL have port ram_instr  input  2  instruction word returned combinationally by the two-bit RAM for address pc.
REQ-006 SHALL have port status_in  input  1  sticky carry flag from the accumulator stage.
REQ-007 SHALL have port pc  output  2  program counter, drives RAM address (pc[0]=LSB s1, pc[1]=MSB s2).
REQ-008 SHALL have port ir  output  2  latched instruction register.
REQ-009 SHALL have port exec_inc  output  1  one-cycle enable to the accumulator/adder stage.
REQ-010 SHALL have port busy  output  1  high in FETCH, DECODE, EXECUTE.
REQ-011 SHALL have port halted  output  1  high in HALT.
REQ-012 SHALL have port retired  output  8  count of completed instructions.

Function
REQ-013 SHALL implement FSM states IDLE, FETCH, DECODE, EXECUTE, HALT.
REQ-014 IDLE: run=1 and halt_req=0 -> FETCH next cycle; otherwise stay; run while busy is ignored.
REQ-015 FETCH: ir <= ram_instr at end of cycle; -> DECODE.
REQ-016 DECODE: no register updates except state; -> EXECUTE.
REQ-017 Opcodes: 00 INC, 01 NOP, 10 BRZ (see Configuration), 11 HLT.
REQ-018 EXECUTE with ir=00: exec_inc=1 for exactly this cycle; exec_inc=0 in all other cycles.
REQ-019 EXECUTE: pc <= pc+1 modulo 4 (3 wraps to 0) unless a taken branch overrides.
REQ-020 EXECUTE with ir=11: pc unchanged; -> HALT; HALT exits only via reset.
REQ-021 EXECUTE, ir!=11: halt_req=1 -> IDLE, else -> FETCH; halt_req in FETCH/DECODE is not latched, sampled only in EXECUTE.
REQ-022 retired SHALL increment by 1 at end of every EXECUTE, including HLT, saturating at 255.
REQ-023 Instruction latency: 3 cycles per instruction (FETCH, DECODE, EXECUTE), no overlap.

Reset
REQ-024 reset=1 SHALL force state=IDLE, pc=00, ir=00, exec_inc=0, busy=0, halted=0, retired=0, in any state including mid-instruction.
REQ-025 reset SHALL take priority over run, halt_req and all FSM transitions in the same cycle.

Configuration
REQ-026 Macro FETCH_BRANCH_EN defined: opcode 10 in EXECUTE with status_in=0 SHALL set pc <= 00 (loop to start); with status_in=1 SHALL fall through to pc+1.
REQ-027 Macro FETCH_BRANCH_EN undefined: opcode 10 SHALL behave exactly as NOP; status_in unused.

Structure
REQ-028 Shared package SHALL hold opcode constants (OP_INC, OP_NOP, OP_BRZ, OP_HLT), state encoding constants, and PC width (2).
REQ-029 Sub-module pc_counter SHALL hold the 2-bit wrapping counter with load (target) and increment controls.
REQ-030 fetch_sequencer SHALL connect directly upstream of the RAM and accumulator stage: pc -> RAM address, exec_inc -> accumulator write enable.

Verification
REQ-031 RAM {00,00,00,00}, run pulse -> exec_inc pulses every 3 cycles, pc 0,1,2,3,0; retired counts 1,2,3,...
REQ-032 RAM {00,01,11,00} -> exec_inc once, halted=1 after 9 cycles from FETCH entry, pc stays 2, retired=3.
REQ-033 FETCH_BRANCH_EN, RAM {00,10,01,01}, status_in=0 -> pc sequence 0,1,0,1...; status_in forced 1 -> pc 0,1,2,3.
REQ-034 halt_req asserted during DECODE of instruction at pc=1 -> no stop; asserted in EXECUTE -> IDLE with pc=2, busy=0.
REQ-035 reset asserted in EXECUTE of INC -> next cycle all outputs zero, no further exec_inc; run afterwards restarts at pc=0.
REQ-036 Saturation: 300 NOP instructions -> retired holds 255.
